// File: rtl/processador_nios2_qsys_0_oci_dct_sequencer_pkg.sv
// processador_nios2_qsys_0_oci_dct_sequencer_pkg: shared states and frame geometry for the DCT trace sequencer
package processador_nios2_qsys_0_oci_dct_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam int FRAME_W = 2;
  localparam int FRAMES_PER_WORD = 16;
  localparam int DCT_FRAMES = 15;
endpackage

// File: rtl/processador_nios2_qsys_0_oci_dct_sequencer_packer.sv
// processador_nios2_qsys_0_oci_dct_packer: appends a capture's frames to the accumulator and splits off a full word
module processador_nios2_qsys_0_oci_dct_packer
  import processador_nios2_qsys_0_oci_dct_sequencer_pkg::*;
(
  input  logic [FRAMES_PER_WORD*FRAME_W-1:0] i_acc,
  input  logic [3:0]                         i_fill,
  input  logic [DCT_FRAMES*FRAME_W-1:0]      i_frames,
  input  logic [3:0]                         i_count,
  output logic [FRAMES_PER_WORD*FRAME_W-1:0] o_acc,
  output logic [3:0]                         o_fill,
  output logic                               o_full,
  output logic [FRAMES_PER_WORD*FRAME_W-1:0] o_word
);
  logic [31:0] w_mask;
  logic [63:0] w_sum;
  logic [4:0]  w_total;
  // frames beyond i_count are masked so unused accumulator frames stay zero
  always_comb begin
    w_mask  = ~(32'hFFFF_FFFF << {i_count, 1'b0});
    w_sum   = {32'd0, i_acc} | ({32'd0, {2'b00, i_frames} & w_mask} << {i_fill, 1'b0});
    w_total = {1'b0, i_fill} + {1'b0, i_count};
    o_full  = w_total[4];
    o_fill  = w_total[3:0];
    o_word  = w_sum[31:0];
    o_acc   = o_full ? w_sum[63:32] : w_sum[31:0];
  end
endmodule

// File: rtl/processador_nios2_qsys_0_oci_dct_sequencer.sv
// processador_nios2_qsys_0_oci_dct_sequencer: packs DCT frames into 32-bit words and writes them to trace RAM
module processador_nios2_qsys_0_oci_dct_sequencer
  import processador_nios2_qsys_0_oci_dct_sequencer_pkg::*;
#(
  parameter int ADDR_W       = 7,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               trace_enable,
  input  logic                               dct_valid,
  input  logic [DCT_FRAMES*FRAME_W-1:0]      dct_buffer,
  input  logic [3:0]                         dct_count,
  output logic                               dct_ready,
  input  logic                               test_ending,
  output logic                               tw_write,
  output logic [ADDR_W-1:0]                  tw_addr,
  output logic [FRAMES_PER_WORD*FRAME_W-1:0] tw_data,
  input  logic                               tw_waitrequest,
  output logic                               test_has_ended,
  output logic                               trace_wrapped
);
  state_t                             r_state, w_next;
  logic [FRAMES_PER_WORD*FRAME_W-1:0] r_acc, r_data, w_p_acc, w_p_word;
  logic [3:0]                         r_fill, w_p_fill;
  logic [ADDR_W-1:0]                  r_addr;
  logic                               r_write, r_ended, r_wrapped, r_low;
  logic                               w_accept, w_done, w_stop, w_leave, w_flush, w_rearm, w_p_full;
  processador_nios2_qsys_0_oci_dct_packer u_packer (
    .i_acc   (r_acc),
    .i_fill  (r_fill),
    .i_frames(dct_buffer),
    .i_count (w_accept ? dct_count : 4'd0),
    .o_acc   (w_p_acc),
    .o_fill  (w_p_fill),
    .o_full  (w_p_full),
    .o_word  (w_p_word)
  );
  assign dct_ready      = (r_state == RUN) && !r_write;
  assign tw_write       = r_write;
  assign tw_addr        = r_addr;
  assign tw_data        = r_data;
  assign test_has_ended = r_ended;
  assign trace_wrapped  = r_wrapped;
  always_comb begin
    w_accept = dct_valid && dct_ready;
    w_done   = r_write && !tw_waitrequest;
    w_stop   = STOP_ON_FULL && w_done && (&r_addr);
    w_leave  = (r_state == RUN) && (test_ending || !trace_enable);
    w_flush  = w_leave || (r_state == FLUSH);
    w_rearm  = (r_state == DONE) && r_low && trace_enable;
    w_next   = r_state;
    if (w_stop) w_next = DONE;
    else if (r_state == IDLE && trace_enable) w_next = RUN;
    else if (w_leave) w_next = FLUSH;
    else if (r_state == FLUSH && (!r_write || w_done) && r_fill == 4'd0) w_next = DONE;
    else if (w_rearm) w_next = IDLE;
  end
  always_ff @(posedge clk) r_state <= !reset_n ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_fill    <= '0;
      r_data    <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_ended   <= 1'b0;
      r_wrapped <= 1'b0;
      r_low     <= 1'b0;
    end else begin
      if (w_done) begin
        r_write   <= 1'b0;
        r_addr    <= r_addr + ADDR_W'(1);
        r_wrapped <= r_wrapped | (&r_addr);
      end
      // a flush request turns whatever is accumulated (plus this capture) into a zero-padded word
      if (w_stop) begin
        r_acc  <= '0;
        r_fill <= '0;
      end else if (w_rearm) begin
        r_acc     <= '0;
        r_fill    <= '0;
        r_addr    <= '0;
        r_wrapped <= 1'b0;
      end else if (!r_write && (w_p_full || (w_flush && w_p_fill != 4'd0))) begin
        r_write <= 1'b1;
        r_data  <= w_p_word;
        r_acc   <= w_p_full ? w_p_acc : '0;
        r_fill  <= w_p_full ? w_p_fill : 4'd0;
      end else if (w_accept) begin
        r_acc  <= w_p_acc;
        r_fill <= w_p_fill;
      end
      r_ended <= w_rearm ? 1'b0 : (r_state == DONE) ? 1'b1 : r_ended;
      r_low   <= (r_state == DONE) && !w_rearm && (r_low || !trace_enable);
    end
  end
endmodule

// File: tb/tb_processador_nios2_qsys_0_oci_dct_sequencer.sv
// tb_processador_nios2_qsys_0_oci_dct_sequencer: directed checks of packing, stall, flush, wrap and reset
module tb_processador_nios2_qsys_0_oci_dct_sequencer;
  logic        clk = 0, reset_n = 0, trace_enable = 0, dct_valid = 0, test_ending = 0, tw_waitrequest = 0;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        dct_ready, tw_write, test_has_ended, trace_wrapped;
  logic [1:0]  tw_addr;
  logic [31:0] tw_data;
  logic        s_ready, s_write, s_ended, s_wrapped;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  int n_vec = 0, n_bad = 0, n_wr0 = 0, n_wr1 = 0;
  always #5 clk = ~clk;
  // u_dut overwrites circularly, u_stop stops at the last address; both share all inputs
  processador_nios2_qsys_0_oci_dct_sequencer #(.ADDR_W(2), .STOP_ON_FULL(1'b0)) u_dut (
    .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_ready(dct_ready), .test_ending(test_ending),
    .tw_write(tw_write), .tw_addr(tw_addr), .tw_data(tw_data), .tw_waitrequest(tw_waitrequest),
    .test_has_ended(test_has_ended), .trace_wrapped(trace_wrapped));
  processador_nios2_qsys_0_oci_dct_sequencer #(.ADDR_W(2), .STOP_ON_FULL(1'b1)) u_stop (
    .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_ready(s_ready), .test_ending(test_ending),
    .tw_write(s_write), .tw_addr(s_addr), .tw_data(s_data), .tw_waitrequest(tw_waitrequest),
    .test_has_ended(s_ended), .trace_wrapped(s_wrapped));
  always @(posedge clk) begin
    if (tw_write && !tw_waitrequest) n_wr0 <= n_wr0 + 1;
    if (s_write && !tw_waitrequest) n_wr1 <= n_wr1 + 1;
  end
  task automatic step;
    @(negedge clk);
  endtask
  task automatic put(input logic [29:0] b, input logic [3:0] c);
    n_vec++; if (dct_ready !== 1'b1) begin n_bad++; $display("FAIL put_ready: got %b want 1", dct_ready); end
    dct_valid = 1; dct_buffer = b; dct_count = c;
    step;
    dct_valid = 0;
  endtask
  task automatic rearm;
    trace_enable = 0; step;
    trace_enable = 1; step;
    n_vec++; if (test_has_ended !== 1'b0) begin n_bad++; $display("FAIL rearm_ended: got %b want 0", test_has_ended); end
    n_vec++; if (trace_wrapped !== 1'b0) begin n_bad++; $display("FAIL rearm_wrapped: got %b want 0", trace_wrapped); end
    n_vec++; if (tw_addr !== 2'd0) begin n_bad++; $display("FAIL rearm_addr: got %0d want 0", tw_addr); end
    step;
  endtask
  task automatic test_reset;
    reset_n = 0; repeat (2) step;
    n_vec++; if (tw_write !== 1'b0) begin n_bad++; $display("FAIL rst_write: got %b want 0", tw_write); end
    n_vec++; if (tw_addr !== 2'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", tw_addr); end
    n_vec++; if (tw_data !== 32'd0) begin n_bad++; $display("FAIL rst_data: got %h want 0", tw_data); end
    n_vec++; if (dct_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", dct_ready); end
    n_vec++; if (test_has_ended !== 1'b0) begin n_bad++; $display("FAIL rst_ended: got %b want 0", test_has_ended); end
    n_vec++; if (trace_wrapped !== 1'b0) begin n_bad++; $display("FAIL rst_wrapped: got %b want 0", trace_wrapped); end
    reset_n = 1; step;
    n_vec++; if (dct_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %b want 0", dct_ready); end
  endtask
  task automatic test_arm;
    trace_enable = 1; step;
    n_vec++; if (dct_ready !== 1'b1) begin n_bad++; $display("FAIL arm_ready: got %b want 1", dct_ready); end
  endtask
  task automatic test_packing;
    logic [29:0] b;
    for (int i = 0; i < 15; i++) b[2*i +: 2] = 2'((i + 1) % 4);
    put(b, 4'd15);
    n_vec++; if (tw_write !== 1'b0) begin n_bad++; $display("FAIL pack_early: got %b want 0", tw_write); end
    put(30'd2, 4'd1);
    n_vec++; if (tw_write !== 1'b1) begin n_bad++; $display("FAIL pack_write: got %b want 1", tw_write); end
    n_vec++; if (tw_addr !== 2'd0) begin n_bad++; $display("FAIL pack_addr: got %0d want 0", tw_addr); end
    n_vec++; if (tw_data !== 32'hB939_3939) begin n_bad++; $display("FAIL pack_data: got %h want b9393939", tw_data); end
    n_vec++; if (dct_ready !== 1'b0) begin n_bad++; $display("FAIL pack_ready: got %b want 0", dct_ready); end
    step;
    n_vec++; if (tw_write !== 1'b0) begin n_bad++; $display("FAIL pack_done: got %b want 0", tw_write); end
    n_vec++; if (tw_addr !== 2'd1) begin n_bad++; $display("FAIL pack_next_addr: got %0d want 1", tw_addr); end
  endtask
  task automatic test_split;
    put(30'h1555_5555, 4'd15);
    put(30'h2AAA_AAAA, 4'd15);
    n_vec++; if (tw_write !== 1'b1) begin n_bad++; $display("FAIL split_write: got %b want 1", tw_write); end
    n_vec++; if (tw_addr !== 2'd1) begin n_bad++; $display("FAIL split_addr: got %0d want 1", tw_addr); end
    n_vec++; if (tw_data !== 32'h9555_5555) begin n_bad++; $display("FAIL split_data: got %h want 95555555", tw_data); end
    step;
    n_vec++; if (tw_addr !== 2'd2) begin n_bad++; $display("FAIL split_next_addr: got %0d want 2", tw_addr); end
  endtask
  task automatic test_stall;
    int n0;
    n0 = n_wr0;
    tw_waitrequest = 1;
    put(30'h0000_000F, 4'd2);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (tw_write !== 1'b1) begin n_bad++; $display("FAIL stall_write[%0d]: got %b want 1", i, tw_write); end
      n_vec++; if (tw_data !== 32'hFAAA_AAAA) begin n_bad++; $display("FAIL stall_data[%0d]: got %h want faaaaaaa", i, tw_data); end
      n_vec++; if (tw_addr !== 2'd2) begin n_bad++; $display("FAIL stall_addr[%0d]: got %0d want 2", i, tw_addr); end
      n_vec++; if (dct_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, dct_ready); end
      step;
    end
    tw_waitrequest = 0; step;
    n_vec++; if (tw_write !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", tw_write); end
    n_vec++; if (tw_addr !== 2'd3) begin n_bad++; $display("FAIL stall_next_addr: got %0d want 3", tw_addr); end
    n_vec++; if (n_wr0 !== n0 + 1) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", n_wr0 - n0, 1); end
  endtask
  task automatic test_wrap;
    put(30'h3FFF_FFFF, 4'd15);
    put(30'h3, 4'd1);
    n_vec++; if (tw_addr !== 2'd3) begin n_bad++; $display("FAIL wrap_addr3: got %0d want 3", tw_addr); end
    n_vec++; if (tw_data !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_data: got %h want ffffffff", tw_data); end
    n_vec++; if (s_write !== 1'b1 || s_addr !== 2'd3) begin n_bad++; $display("FAIL stop_last_write: got %b/%0d want 1/3", s_write, s_addr); end
    step;
    n_vec++; if (tw_addr !== 2'd0) begin n_bad++; $display("FAIL wrap_addr0: got %0d want 0", tw_addr); end
    n_vec++; if (trace_wrapped !== 1'b1) begin n_bad++; $display("FAIL wrap_flag: got %b want 1", trace_wrapped); end
    n_vec++; if (s_ended !== 1'b0) begin n_bad++; $display("FAIL stop_ended_early: got %b want 0", s_ended); end
    step;
    n_vec++; if (s_ended !== 1'b1) begin n_bad++; $display("FAIL stop_ended: got %b want 1", s_ended); end
    n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL stop_ready: got %b want 0", s_ready); end
    put(30'h1555_5555, 4'd15);
    put(30'h1, 4'd1);
    n_vec++; if (tw_write !== 1'b1 || tw_addr !== 2'd0) begin n_bad++; $display("FAIL wrap_fifth: got %b/%0d want 1/0", tw_write, tw_addr); end
    n_vec++; if (tw_data !== 32'h5555_5555) begin n_bad++; $display("FAIL wrap_fifth_data: got %h want 55555555", tw_data); end
    n_vec++; if (s_write !== 1'b0) begin n_bad++; $display("FAIL stop_no_write: got %b want 0", s_write); end
    step;
    n_vec++; if (n_wr1 !== 4) begin n_bad++; $display("FAIL stop_count: got %0d want 4", n_wr1); end
  endtask
  task automatic test_flush;
    int n0;
    put(30'h3F, 4'd3);
    n_vec++; if (tw_write !== 1'b0) begin n_bad++; $display("FAIL flush_early: got %b want 0", tw_write); end
    test_ending = 1; step; test_ending = 0;
    n_vec++; if (tw_write !== 1'b1) begin n_bad++; $display("FAIL flush_write: got %b want 1", tw_write); end
    n_vec++; if (tw_data !== 32'h0000_003F) begin n_bad++; $display("FAIL flush_data: got %h want 0000003f", tw_data); end
    n_vec++; if (tw_addr !== 2'd1) begin n_bad++; $display("FAIL flush_addr: got %0d want 1", tw_addr); end
    step;
    n_vec++; if (test_has_ended !== 1'b0) begin n_bad++; $display("FAIL flush_ended_early: got %b want 0", test_has_ended); end
    step;
    n_vec++; if (test_has_ended !== 1'b1) begin n_bad++; $display("FAIL flush_ended: got %b want 1", test_has_ended); end
    n_vec++; if (trace_wrapped !== 1'b1) begin n_bad++; $display("FAIL flush_wrapped_sticky: got %b want 1", trace_wrapped); end
    rearm;
    n0 = n_wr0;
    test_ending = 1; step; test_ending = 0;
    n_vec++; if (tw_write !== 1'b0) begin n_bad++; $display("FAIL empty_flush_write: got %b want 0", tw_write); end
    repeat (2) step;
    n_vec++; if (test_has_ended !== 1'b1) begin n_bad++; $display("FAIL empty_flush_ended: got %b want 1", test_has_ended); end
    n_vec++; if (n_wr0 !== n0) begin n_bad++; $display("FAIL empty_flush_count: got %0d want 0", n_wr0 - n0); end
  endtask
  task automatic test_reset_mid_write;
    rearm;
    put(30'h3FFF_FFFF, 4'd15);
    put(30'h3, 4'd1);
    step;
    n_vec++; if (tw_addr !== 2'd1) begin n_bad++; $display("FAIL rmw_addr1: got %0d want 1", tw_addr); end
    tw_waitrequest = 1;
    put(30'h3FFF_FFFF, 4'd15);
    put(30'h3, 4'd1);
    n_vec++; if (tw_write !== 1'b1) begin n_bad++; $display("FAIL rmw_write: got %b want 1", tw_write); end
    reset_n = 0; step;
    n_vec++; if (tw_write !== 1'b0) begin n_bad++; $display("FAIL rmw_drop: got %b want 0", tw_write); end
    n_vec++; if (tw_addr !== 2'd0) begin n_bad++; $display("FAIL rmw_addr: got %0d want 0", tw_addr); end
    n_vec++; if (tw_data !== 32'd0) begin n_bad++; $display("FAIL rmw_data: got %h want 0", tw_data); end
    n_vec++; if (dct_ready !== 1'b0) begin n_bad++; $display("FAIL rmw_ready: got %b want 0", dct_ready); end
    reset_n = 1; tw_waitrequest = 0; step;
    put(30'h1555_5555, 4'd15);
    put(30'h1, 4'd1);
    n_vec++; if (tw_write !== 1'b1 || tw_addr !== 2'd0) begin n_bad++; $display("FAIL rmw_restart: got %b/%0d want 1/0", tw_write, tw_addr); end
    step;
  endtask
  initial begin
    test_reset;
    test_arm;
    test_packing;
    test_split;
    test_stall;
    test_wrap;
    test_flush;
    test_reset_mid_write;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/processador_nios2_qsys_0_oci_dct_sequencer.md
# processador_nios2_qsys_0_oci_dct_sequencer

Sequences Nios II OCI data/control trace (DCT) capture into on-chip trace memory. It accepts packed 2-bit trace frames from the DCT capture stage, accumulates them into 32-bit trace words, and writes those words to the trace RAM through a waitrequest handshake with a wrapping address counter. It also handles the end-of-test flush that pads and commits a partial word before signalling completion. It sits between the OCI trace capture logic and the trace RAM and is the sole writer of that RAM.

## Interface
- ADDR_W, 7: trace RAM word-address width.
- STOP_ON_FULL, 0: 1 = stop at address wrap; 0 = circular overwrite.
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- trace_enable  in  1  level; 1 arms capture from IDLE.
- dct_valid  in  1  dct_buffer/dct_count are valid this cycle.
- dct_buffer  in  30  15 frames; frame i = dct_buffer[2i+1:2i]; frame 0 is oldest.
- dct_count  in  4  number of valid frames, 0..15.
- dct_ready  out  1  capture accepted when dct_valid && dct_ready.
- test_ending  in  1  pulse or level; requests flush.
- tw_write  out  1  trace RAM write request.
- tw_addr  out  ADDR_W  word address.
- tw_data  out  32  trace word; frame k of the word sits at bits [2k+1:2k].
- tw_waitrequest  in  1  RAM stall; a write completes on tw_write && !tw_waitrequest.
- test_has_ended  out  1  flush complete; sticky until reset or re-arm.
- trace_wrapped  out  1  sticky; set when the address wraps.

## Operation
- States:
  - IDLE -> RUN when trace_enable = 1.
  - RUN -> FLUSH on test_ending = 1, or when trace_enable = 0.
  - FLUSH -> DONE once the padded partial word (if any) and any pending write have completed.
  - DONE -> IDLE when trace_enable is low, then high again (re-arm). Re-arm clears test_has_ended, trace_wrapped, the address and the accumulator.
- Accumulator: 32-bit acc plus fill (0..15 frames).
  - On accept, the incoming frames are appended at position fill.
  - If fill + dct_count >= 16: the low 16 frames form the pending word, the excess frames go to acc[...] starting at frame 0, and fill becomes fill + dct_count - 16. Otherwise fill becomes fill + dct_count.
  - dct_count = 0 is accepted and changes nothing.
- Pending word: one-entry output register.
  - dct_ready = (state == RUN) && !tw_write.
  - While a word is pending, no capture is accepted, so one capture can never produce two words.
- Address:
  - tw_addr increments after each completed write. 2^ADDR_W - 1 wraps to 0 and sets trace_wrapped.
  - With STOP_ON_FULL = 1, completing the write to the last address forces DONE; test_has_ended is set and the accumulator contents are dropped.
- Flush: if fill > 0, the word is acc with unused frames zero, written as a normal word; fill then clears. If fill = 0, no write occurs.
- test_ending arriving while a word is pending: the pending write completes first, then the flush word is written.
- dct_valid outside RUN is ignored.

## Timing
- Reset values: tw_write = 0, tw_addr = 0, tw_data = 0, dct_ready = 0, test_has_ended = 0, trace_wrapped = 0; state = IDLE, fill = 0.
- Reset asserted mid-write drops the write immediately (synchronous).
- Latency: a capture accepted in cycle N that completes a word drives tw_write = 1 in N+1. tw_data and tw_addr stay stable while tw_waitrequest = 1.
- Throughput: with no stall, one word every 2 cycles at most, because dct_ready is low for the cycle in which tw_write is high.
- test_has_ended rises the cycle after entering DONE. From test_ending in RUN with fill > 0 and no stall, the flush write is issued 1 cycle later and test_has_ended is high 3 cycles after test_ending.
- IDLE -> RUN takes 1 cycle; dct_ready is high the cycle after trace_enable rises.

## Structure
- Shared package holds: state enum (IDLE, RUN, FLUSH, DONE), FRAME_W = 2, FRAMES_PER_WORD = 16, DCT_FRAMES = 15.
- One sub-module, processador_nios2_qsys_0_oci_dct_packer: purely combinational append/split of acc + frames, producing the next acc, next fill, a word-complete flag and the word.
- Top level holds the FSM, pending register, address counter and sticky flags.

## Test plan
- Packing: after arm, capture count = 15 of frames 1,2,3,0,... then count = 1 of frame 2 -> one write at addr 0 with tw_data frames 0..15 in that order; fill = 0.
- Split across words: count = 15, then count = 15 -> first word = 15 frames + 1st frame of the 2nd capture; fill = 14.
- Stall: hold tw_waitrequest high for 5 cycles -> tw_data/tw_addr stable, dct_ready = 0 throughout; exactly one write completes.
- Flush: fill = 3 (frames 3,3,3), pulse test_ending -> tw_data = 32'h0000003F, then test_has_ended = 1. With fill = 0 -> no write, test_has_ended = 1.
- Wrap, ADDR_W = 2: 5 words with STOP_ON_FULL = 0 -> addresses 0,1,2,3,0 and trace_wrapped = 1. With STOP_ON_FULL = 1 -> 4 writes, then DONE and test_has_ended = 1.
- Reset mid-write: reset_n low while tw_write = 1 and stalled -> next cycle all outputs at reset values; a later re-arm starts at addr 0.
